// File: rtl/i2c_line_conditioner_pkg.sv
// Shared types and defaults for the I2C line conditioner.
package i2c_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } bus_state_e;

  localparam int unsigned DEF_FILT_LEN    = 4;
  localparam int unsigned DEF_TIMEOUT_CYC = 50000;

endpackage

// File: rtl/i2c_line_conditioner_if.sv
// Pin-side inputs and conditioned outputs of the I2C line conditioner.
// bus_timeout exists only when I2C_TIMEOUT_EN is defined.
interface i2c_line_conditioner_if;
  logic scl_in;
  logic sda_in;
  logic scl_f;
  logic sda_f;
  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;
  logic bus_busy;
`ifdef I2C_TIMEOUT_EN
  logic bus_timeout;
`endif

  // Conditioner side: samples pins, drives conditioned levels and strobes.
  modport slave (
    input  scl_in, sda_in,
    output scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, bus_busy
`ifdef I2C_TIMEOUT_EN
    , output bus_timeout
`endif
  );

  // Pin/consumer side: drives pins, observes conditioned outputs.
  modport master (
    output scl_in, sda_in,
    input  scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, bus_busy
`ifdef I2C_TIMEOUT_EN
    , input bus_timeout
`endif
  );
endinterface

// File: rtl/i2c_line_conditioner_sync_filter.sv
// Two-flop synchronizer plus glitch filter for one open-drain I2C line.
// The filtered level follows sync2 only after FILT_LEN consecutive mismatches.
module i2c_sync_filter
  import i2c_pkg::*;
#(
  parameter int unsigned FILT_LEN = DEF_FILT_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_in,
  output logic level_f
);

  localparam int unsigned CW = $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Next-state: shift synchronizer, count mismatches, accept on the FILT_LEN-th.
  always_comb begin
    sync1_d = pin_in;
    sync2_d = sync1_q;
    filt_d  = filt_q;
    cnt_d   = cnt_q;
    if (sync2_q == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      filt_d = sync2_q;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // State register; idle-high reset level on the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_f = filt_q;

endmodule

// File: rtl/i2c_line_conditioner.sv
// I2C pin conditioner: synchronize and filter SCL/SDA, then derive SCL edge,
// START/STOP strobes and bus-busy state. Optional SCL-stuck-low timeout is
// enabled with the I2C_TIMEOUT_EN macro.
module i2c_line_conditioner
  import i2c_pkg::*;
#(
  parameter int unsigned FILT_LEN    = DEF_FILT_LEN,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input logic               clk,
  input logic               rst,
  i2c_line_conditioner_if.slave bus
);

  logic scl_f, sda_f;

  i2c_sync_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk     (clk),
    .rst     (rst),
    .pin_in  (bus.scl_in),
    .level_f (scl_f)
  );

  i2c_sync_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk     (clk),
    .rst     (rst),
    .pin_in  (bus.sda_in),
    .level_f (sda_f)
  );

  logic       scl_d_q, scl_d_d;
  logic       sda_d_q, sda_d_d;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;
  logic       start_q, start_d;
  logic       stop_q, stop_d;
  bus_state_e state_q, state_d;
`ifdef I2C_TIMEOUT_EN
  logic [31:0] to_cnt_q, to_cnt_d;
  logic        timeout_q, timeout_d;
`endif

  // Next-state: edge/condition strobes from filtered levels, bus state update.
  always_comb begin
    scl_d_d = scl_f;
    sda_d_d = sda_f;
    rise_d  = !scl_d_q & scl_f;
    fall_d  = scl_d_q & !scl_f;
    start_d = sda_d_q & !sda_f & scl_d_q & scl_f;
    stop_d  = !sda_d_q & sda_f & scl_d_q & scl_f;
    state_d = state_q;
    if (start_q) begin
      state_d = BUSY;
    end else if (stop_q) begin
      state_d = IDLE;
    end
`ifdef I2C_TIMEOUT_EN
    timeout_d = timeout_q;
    to_cnt_d  = '0;
    if (start_q) begin
      timeout_d = 1'b0;
    end
    if (state_q == BUSY && !scl_f) begin
      if (to_cnt_q == 32'(TIMEOUT_CYC - 1)) begin
        timeout_d = 1'b1;
        state_d   = IDLE;
      end else begin
        to_cnt_d = to_cnt_q + 32'd1;
      end
    end
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_d_q <= 1'b1;
      sda_d_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      state_q <= IDLE;
`ifdef I2C_TIMEOUT_EN
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      scl_d_q <= scl_d_d;
      sda_d_q <= sda_d_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      state_q <= state_d;
`ifdef I2C_TIMEOUT_EN
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign bus.scl_f     = scl_f;
  assign bus.sda_f     = sda_f;
  assign bus.scl_rise  = rise_q;
  assign bus.scl_fall  = fall_q;
  assign bus.start_det = start_q;
  assign bus.stop_det  = stop_q;
  assign bus.bus_busy  = (state_q == BUSY);
`ifdef I2C_TIMEOUT_EN
  assign bus.bus_timeout = timeout_q;
`endif

endmodule
